ternary_popcount_acc: RTL and testbench
=======================================

// Module: ternary_popcount_acc
// PURPOSE
//  Streaming ternary-neuron core: each beat carries a positive and a negative WIDTH-bit activation vector.
//  Accumulates sum(popcount(pos) - popcount(neg)) over a multi-beat frame and emits the signed sum plus a ternary activation.
//  Generalises the fixed 22-input popcount to any width, multi-beat frames and an optional approximate (LSB-truncated) count.
//  Sits between the sensor-side bit packer and the layer output register file.
// PARAMETERS
//  WIDTH      22  bits per vector per beat
//  MAX_BEATS  16  beats per frame; beat MAX_BEATS forces frame end
//  ACC_W      12  signed accumulator width; must satisfy ACC_W >= $clog2(WIDTH*MAX_BEATS+1)+1
//  TRUNC      0   per-beat popcount LSBs zeroed (0 = exact); legal range 0..PC_W-1
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       beat valid
//  in_ready   out  1       block accepts beat; beat transfers when in_valid & in_ready
//  in_pos     in   WIDTH   activations of +1 weights
//  in_neg     in   WIDTH   activations of -1 weights
//  in_last    in   1       final beat of frame
//  thr_hi     in   ACC_W   signed; sampled on the first beat of a frame
//  thr_lo     in   ACC_W   signed; sampled on the first beat of a frame; thr_lo <= thr_hi required
//  out_valid  out  1       result valid; held until out_ready
//  out_ready  in   1       consumer accepts result
//  out_sum    out  ACC_W   signed saturated frame sum
//  out_act    out  2       2'b01 = +1 (sum > thr_hi); 2'b11 = -1 (sum < thr_lo); 2'b00 otherwise
//  out_ovf    out  1       frame forced closed at MAX_BEATS without in_last, or accumulator saturated
// BEHAVIOUR
//  - Reset: state ACC; in_ready=1; out_valid=0; out_sum=0; out_act=0; out_ovf=0. Accumulator, beat counter and pipe valid bits cleared. An in-flight frame is discarded.
//  - Stage S1 (registered): pc_p = popcount(in_pos), pc_n = popcount(in_neg); each is PC_W=$clog2(WIDTH+1) bits.
//    When TRUNC>0, the low TRUNC bits of each count are zeroed before registering.
//  - Stage S2 (registered): acc <= (first ? 0 : acc) + (pc_p - pc_n).
//    Addition is sign-extended to ACC_W and clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; a clamp sets a sticky sat flag for the frame.
//  - Beat counter: counts accepted beats, 1..MAX_BEATS. Reaching MAX_BEATS without in_last treats that beat as last and sets the sticky ovf flag.
//  - FSM:
//    ACC: in_ready=1. Accepting a last beat (in_last or forced) -> FLUSH.
//    FLUSH: in_ready=0; waits while the last beat traverses S1/S2, then -> HOLD.
//    HOLD: out_valid=1 and out_* stable until out_valid & out_ready; -> ACC that cycle. in_ready rises the next cycle.
//  - Latency: last beat accepted at edge E. out_valid is high after edge E+2. Minimum frame period is beats+3 cycles with out_ready tied high.
//  - Activation: computed from the final sum and the thresholds latched on the frame's first beat. Ties (sum==thr_hi or sum==thr_lo) give 0.
//  - out_ovf = ovf | sat for the frame. Both flags clear at frame start.
//  - A single-beat frame (first & last together) is legal; acc is loaded, not added.
//  - in_valid low mid-frame: bubble; the accumulator holds; the beat counter does not advance.
//  - Inputs other than in_valid are don't-care while in_ready=0.
// STRUCTURE
//  - Package tnn_pkg: act_e enum (ACT_ZERO=2'b00, ACT_POS=2'b01, ACT_NEG=2'b11); fsm_e state enum (ACC, FLUSH, HOLD); clog2-based PC_W helper.
//  - Sub-module popcount_tree #(WIDTH, TRUNC): purely combinational adder tree (full-adder compression, ripple final add), instantiated twice (pos/neg).
//  - Top module holds the S1/S2 registers, beat counter, saturation logic, threshold latch and FSM.
// TESTING
//  1. Reset mid-frame after 3 beats -> out_valid=0, in_ready=1 next cycle. A following 1-beat frame with pos=all-ones, neg=0 gives out_sum=22.
//  2. Single beat, WIDTH=22, pos=22'h3FFFFF, neg=22'h000001, thr_hi=10, thr_lo=-10 -> out_sum=21, out_act=01, out_ovf=0, out_valid 2 edges after accept.
//  3. 4-beat frame, pos=0, neg=all-ones each beat, thr_lo=-50 -> out_sum=-88, out_act=11. in_ready=0 from beat-4 accept until the result handshake.
//  4. out_ready held low 5 cycles in HOLD -> out_* stable, in_ready=0 throughout; out_ready=1 -> next frame accepted the cycle after.
//  5. MAX_BEATS=16, 16 beats of pos=all-ones with no in_last -> forced end, out_sum=352, out_ovf=1. ACC_W=8 variant -> out_sum=127, out_ovf=1.
//  6. TRUNC=1, pos with 7 ones, neg with 2 ones -> per-beat diff 6-2=4, out_sum=4. Sum==thr_hi=4 gives out_act=00.

Source files
------------

// File: rtl/ternary_popcount_acc_pkg.sv
// Shared types for the ternary popcount accumulator: activation codes, FSM states and
// the popcount width helper.
package tnn_pkg;

    typedef enum logic [1:0] {
        ACT_ZERO = 2'b00,
        ACT_POS  = 2'b01,
        ACT_NEG  = 2'b11
    } act_e;

    typedef enum logic [1:0] {
        ACC,
        FLUSH,
        HOLD
    } fsm_e;

    function automatic int unsigned pc_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/ternary_popcount_acc_if.sv
// Beat input / result output bundle of the ternary popcount accumulator.
// master is the producer/consumer side; slave is the accumulator itself.
interface ternary_popcount_acc_if #(
    parameter int unsigned WIDTH = 22,
    parameter int unsigned ACC_W = 12
);

    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_pos;
    logic [WIDTH-1:0]        in_neg;
    logic                    in_last;
    logic signed [ACC_W-1:0] thr_hi;
    logic signed [ACC_W-1:0] thr_lo;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic [1:0]              out_act;
    logic                    out_ovf;

    modport master (
        output in_valid, in_pos, in_neg, in_last, thr_hi, thr_lo, out_ready,
        input  in_ready, out_valid, out_sum, out_act, out_ovf
    );

    modport slave (
        input  in_valid, in_pos, in_neg, in_last, thr_hi, thr_lo, out_ready,
        output in_ready, out_valid, out_sum, out_act, out_ovf
    );

endinterface

// File: rtl/ternary_popcount_acc_popcount_tree.sv
// Combinational popcount: full adders compress bit triples into 2-bit counts, which are
// then summed in a ripple chain. Optionally zeroes the low TRUNC bits of the result.
module popcount_tree
    import tnn_pkg::*;
#(
    parameter int unsigned WIDTH = 22,
    parameter int unsigned TRUNC = 0
) (
    input  logic [WIDTH-1:0]              bits,
    output logic [pc_width(WIDTH)-1:0]    count
);

    localparam int unsigned PC_W = pc_width(WIDTH);
    localparam int unsigned NFA  = (WIDTH + 2) / 3;
    localparam logic [PC_W-1:0] MASK = ~PC_W'((1 << TRUNC) - 1);

    logic [3*NFA-1:0] padded;
    logic [NFA-1:0]   fa_s;
    logic [NFA-1:0]   fa_c;
    logic [PC_W-1:0]  raw;

    assign padded = (3 * NFA)'(bits);

    for (genvar i = 0; i < NFA; i++) begin : g_fa
        logic a, b, c;
        assign a       = padded[3*i];
        assign b       = padded[3*i+1];
        assign c       = padded[3*i+2];
        assign fa_s[i] = a ^ b ^ c;
        assign fa_c[i] = (a & b) | (c & (a ^ b));
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < NFA; i++) begin
            raw = raw + PC_W'({fa_c[i], fa_s[i]});
        end
    end

    assign count = raw & MASK;

endmodule

// File: rtl/ternary_popcount_acc.sv
// Streaming ternary neuron: accumulates popcount(pos) - popcount(neg) over a frame through a
// two-stage pipe, saturates, and presents the sum with a thresholded ternary activation.
module ternary_popcount_acc
    import tnn_pkg::*;
#(
    parameter int unsigned WIDTH     = 22,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned ACC_W     = 12,
    parameter int unsigned TRUNC     = 0
) (
    input logic                   clk,
    input logic                   rst,
    ternary_popcount_acc_if.slave bus
);

    localparam int unsigned PC_W  = pc_width(WIDTH);
    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

    fsm_e                    state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    accept, first_beat, last_beat, forced;
    logic [PC_W-1:0]         pc_p, pc_n, pc_p_q, pc_n_q;
    logic                    s1_valid_q, s1_first_q, s1_last_q, s2_last_q;
    logic signed [ACC_W-1:0] acc_q, thr_hi_q, thr_lo_q;
    logic [ACC_W-1:0]        base, acc_next;
    logic [PC_W+1:0]         diff;
    logic [ACC_W+1:0]        base_ext, diff_ext, sum_ext;
    logic                    clamp, sat_q, ovf_q;
    act_e                    act;

    popcount_tree #(.WIDTH(WIDTH), .TRUNC(TRUNC)) u_pc_pos (.bits(bus.in_pos), .count(pc_p));
    popcount_tree #(.WIDTH(WIDTH), .TRUNC(TRUNC)) u_pc_neg (.bits(bus.in_neg), .count(pc_n));

    assign accept     = bus.in_valid && bus.in_ready;
    assign first_beat = (cnt_q == '0);
    assign forced     = (cnt_q == LAST_CNT) && !bus.in_last;
    assign last_beat  = bus.in_last || (cnt_q == LAST_CNT);
    assign cnt_d      = accept ? (last_beat ? '0 : cnt_q + 1'b1) : cnt_q;

    // Two guard bits: any out-of-range sum shows up as disagreement in the top three bits.
    always_comb begin
        base     = s1_first_q ? '0 : acc_q;
        diff     = {2'b00, pc_p_q} - {2'b00, pc_n_q};
        diff_ext = {{(ACC_W - PC_W){diff[PC_W+1]}}, diff};
        base_ext = {{2{base[ACC_W-1]}}, base};
        sum_ext  = base_ext + diff_ext;
        clamp    = sum_ext[ACC_W+1:ACC_W-1] != {3{sum_ext[ACC_W+1]}};
        acc_next = sum_ext[ACC_W-1:0];
        if (clamp) begin
            acc_next = sum_ext[ACC_W+1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            ACC: begin
                bus.in_ready = 1'b1;
                if (accept && last_beat) state_d = FLUSH;
            end
            FLUSH: begin
                if (s2_last_q) state_d = HOLD;
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = ACC;
            end
            default: state_d = ACC;
        endcase
    end

    always_comb begin
        act = ACT_ZERO;
        if (acc_q > thr_hi_q) begin
            act = ACT_POS;
        end else if (acc_q < thr_lo_q) begin
            act = ACT_NEG;
        end
    end

    assign bus.out_sum = acc_q;
    assign bus.out_act = act;
    assign bus.out_ovf = ovf_q | sat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACC;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_last_q  <= 1'b0;
            pc_p_q     <= '0;
            pc_n_q     <= '0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
            thr_hi_q   <= '0;
            thr_lo_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= accept;
            s1_last_q  <= accept && last_beat;
            s2_last_q  <= s1_valid_q && s1_last_q;
            if (accept) begin
                s1_first_q <= first_beat;
                pc_p_q     <= pc_p;
                pc_n_q     <= pc_n;
                ovf_q      <= (first_beat ? 1'b0 : ovf_q) | forced;
                if (first_beat) begin
                    thr_hi_q <= bus.thr_hi;
                    thr_lo_q <= bus.thr_lo;
                end
            end
            if (s1_valid_q) begin
                acc_q <= acc_next;
                sat_q <= (s1_first_q ? 1'b0 : sat_q) | clamp;
            end
        end
    end

endmodule

// File: tb/tb_ternary_popcount_acc.sv
// Bench for ternary_popcount_acc: three configurations (default, ACC_W=8, TRUNC=1) run in
// lockstep on shared stimulus and are compared against an arithmetic frame model.
module tb_ternary_popcount_acc;

    localparam int unsigned W = 22;
    localparam int TR[3] = '{0, 0, 1};
    localparam int AW[3] = '{12, 8, 12};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ternary_popcount_acc_if #(.WIDTH(W), .ACC_W(12)) bus ();
    ternary_popcount_acc_if #(.WIDTH(W), .ACC_W(8))  bus8 ();
    ternary_popcount_acc_if #(.WIDTH(W), .ACC_W(12)) bust ();

    assign bus8.in_valid  = bus.in_valid;
    assign bus8.in_pos    = bus.in_pos;
    assign bus8.in_neg    = bus.in_neg;
    assign bus8.in_last   = bus.in_last;
    assign bus8.thr_hi    = bus.thr_hi[7:0];
    assign bus8.thr_lo    = bus.thr_lo[7:0];
    assign bus8.out_ready = bus.out_ready;
    assign bust.in_valid  = bus.in_valid;
    assign bust.in_pos    = bus.in_pos;
    assign bust.in_neg    = bus.in_neg;
    assign bust.in_last   = bus.in_last;
    assign bust.thr_hi    = bus.thr_hi;
    assign bust.thr_lo    = bus.thr_lo;
    assign bust.out_ready = bus.out_ready;

    ternary_popcount_acc #(.WIDTH(W), .MAX_BEATS(16), .ACC_W(12), .TRUNC(0)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    ternary_popcount_acc #(.WIDTH(W), .MAX_BEATS(16), .ACC_W(8), .TRUNC(0)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8)
    );
    ternary_popcount_acc #(.WIDTH(W), .MAX_BEATS(16), .ACC_W(12), .TRUNC(1)) dut_t (
        .clk(clk), .rst(rst), .bus(bust)
    );

    int checks = 0;
    int passes = 0;

    logic [W-1:0] fpos[16];
    logic [W-1:0] fneg[16];
    int nb;
    bit use_last;
    int th_hi, th_lo;
    bit bubbles;

    int         obs_sum[3];
    logic [1:0] obs_act[3];
    logic       obs_ovf[3];
    int         obs_lat, obs_first_wait;
    bit         obs_rdy_bad, obs_unstable, obs_stall;
    logic       obs_rdy_after, obs_valid_after;

    int         exp_sum[3];
    logic [1:0] exp_act[3];
    bit         exp_ovf[3];

    // Frame result from the arithmetic rules: truncated counts, running clamp, threshold compare.
    function automatic void ref_frame(input int trunc, input int accw, output int sum,
                                      output bit ovf, output logic [1:0] act);
        int hi, lo, q, d;
        hi  = (1 << (accw - 1)) - 1;
        lo  = -(1 << (accw - 1));
        q   = 1 << trunc;
        sum = 0;
        ovf = (nb == 16) && !use_last;
        for (int b = 0; b < nb; b++) begin
            d   = ($countones(fpos[b]) / q) * q - ($countones(fneg[b]) / q) * q;
            sum = sum + d;
            if (sum > hi) begin
                sum = hi;
                ovf = 1'b1;
            end else if (sum < lo) begin
                sum = lo;
                ovf = 1'b1;
            end
        end
        act = (sum > th_hi) ? 2'b01 : (sum < th_lo) ? 2'b11 : 2'b00;
    endfunction

    task automatic compute_expected();
        for (int v = 0; v < 3; v++) ref_frame(TR[v], AW[v], exp_sum[v], exp_ovf[v], exp_act[v]);
    endtask

    task automatic sample_outputs();
        obs_sum[0] = bus.out_sum;
        obs_sum[1] = bus8.out_sum;
        obs_sum[2] = bust.out_sum;
        obs_act[0] = bus.out_act;
        obs_act[1] = bus8.out_act;
        obs_act[2] = bust.out_act;
        obs_ovf[0] = bus.out_ovf;
        obs_ovf[1] = bus8.out_ovf;
        obs_ovf[2] = bust.out_ovf;
    endtask

    // Entered and left just after a falling edge. Thresholds on non-first beats are junk.
    task automatic run_frame(input int hold);
        int wt;
        obs_rdy_bad = 0;
        obs_unstable = 0;
        obs_stall = 0;
        obs_first_wait = 0;
        for (int b = 0; b < nb; b++) begin
            if (b > 0) @(negedge clk);
            if (bubbles && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_pos   = W'($urandom);
                bus.in_neg   = W'($urandom);
                bus.in_last  = 1'($urandom);
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_pos   = fpos[b];
            bus.in_neg   = fneg[b];
            bus.in_last  = (b == nb - 1) && use_last;
            bus.thr_hi   = (b == 0) ? 12'(th_hi) : 12'($urandom);
            bus.thr_lo   = (b == 0) ? 12'(th_lo) : 12'($urandom);
            wt = 0;
            while (!bus.in_ready && wt < 20) begin
                @(negedge clk);
                wt++;
            end
            if (b == 0) obs_first_wait = wt;
            if (!bus.in_ready) obs_stall = 1;
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        obs_lat = 0;
        while (!bus.out_valid && obs_lat < 10) begin
            if (bus.in_ready) obs_rdy_bad = 1;
            @(negedge clk);
            obs_lat++;
        end
        sample_outputs();
        for (int i = 0; i < hold; i++) begin
            if (bus.in_ready) obs_rdy_bad = 1;
            @(negedge clk);
            if (!bus.out_valid || bus.out_sum != obs_sum[0] || bus8.out_sum != obs_sum[1] ||
                bust.out_sum != obs_sum[2] || bus.out_act != obs_act[0] ||
                bus.out_ovf != obs_ovf[0]) obs_unstable = 1;
        end
        if (bus.in_ready) obs_rdy_bad = 1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        obs_rdy_after   = bus.in_ready;
        obs_valid_after = bus.out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passes++;
        checks++; if (bus.out_sum !== 12'sd0) $display("FAIL reset_out_sum: got %0d want 0", bus.out_sum); else passes++;
        checks++; if (bus.out_act !== 2'b00) $display("FAIL reset_out_act: got %b want 00", bus.out_act); else passes++;
        checks++; if (bus.out_ovf !== 1'b0) $display("FAIL reset_out_ovf: got %b want 0", bus.out_ovf); else passes++;
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_pos   = W'($urandom);
            bus.in_neg   = W'($urandom);
            bus.in_last  = 1'b0;
            bus.thr_hi   = 12'sd0;
            bus.thr_lo   = 12'sd0;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); else passes++;
        nb = 1; use_last = 1; bubbles = 0; th_hi = 0; th_lo = 0;
        fpos[0] = '1;
        fneg[0] = '0;
        run_frame(0);
        checks++; if (obs_sum[0] !== 22) $display("FAIL midrst_sum: got %0d want 22", obs_sum[0]); else passes++;
        checks++; if (obs_ovf[0] !== 1'b0) $display("FAIL midrst_ovf: got %b want 0", obs_ovf[0]); else passes++;
    endtask

    task automatic test_single_beat();
        nb = 1; use_last = 1; bubbles = 0; th_hi = 10; th_lo = -10;
        fpos[0] = 22'h3FFFFF;
        fneg[0] = 22'h000001;
        run_frame(0);
        checks++; if (obs_lat !== 2) $display("FAIL single_latency: got %0d want 2", obs_lat); else passes++;
        checks++; if (obs_sum[0] !== 21) $display("FAIL single_sum: got %0d want 21", obs_sum[0]); else passes++;
        checks++; if (obs_act[0] !== 2'b01) $display("FAIL single_act: got %b want 01", obs_act[0]); else passes++;
        checks++; if (obs_ovf[0] !== 1'b0) $display("FAIL single_ovf: got %b want 0", obs_ovf[0]); else passes++;
        checks++; if (obs_sum[2] !== 22) $display("FAIL single_trunc_sum: got %0d want 22", obs_sum[2]); else passes++;
        checks++; if (obs_valid_after !== 1'b0 || obs_rdy_after !== 1'b1)
            $display("FAIL single_release: got valid=%b ready=%b want valid=0 ready=1", obs_valid_after, obs_rdy_after);
        else passes++;
    endtask

    task automatic test_neg_frame();
        nb = 4; use_last = 1; bubbles = 0; th_hi = 50; th_lo = -50;
        for (int b = 0; b < 4; b++) begin
            fpos[b] = '0;
            fneg[b] = '1;
        end
        run_frame(0);
        checks++; if (obs_sum[0] !== -88) $display("FAIL neg_sum: got %0d want -88", obs_sum[0]); else passes++;
        checks++; if (obs_act[0] !== 2'b11) $display("FAIL neg_act: got %b want 11", obs_act[0]); else passes++;
        checks++; if (obs_sum[1] !== -88) $display("FAIL neg_sum_w8: got %0d want -88", obs_sum[1]); else passes++;
        checks++; if (obs_rdy_bad !== 1'b0) $display("FAIL neg_in_ready_low: got %b want 0", obs_rdy_bad); else passes++;
    endtask

    task automatic test_hold();
        nb = 3; use_last = 1; bubbles = 0; th_hi = 5; th_lo = -5;
        for (int b = 0; b < 3; b++) begin
            fpos[b] = W'($urandom);
            fneg[b] = W'($urandom);
        end
        compute_expected();
        run_frame(5);
        checks++; if (obs_unstable !== 1'b0) $display("FAIL hold_stable: got %b want 0", obs_unstable); else passes++;
        checks++; if (obs_rdy_bad !== 1'b0) $display("FAIL hold_in_ready_low: got %b want 0", obs_rdy_bad); else passes++;
        checks++; if (obs_sum[0] !== exp_sum[0]) $display("FAIL hold_sum: got %0d want %0d", obs_sum[0], exp_sum[0]); else passes++;
        checks++; if (obs_rdy_after !== 1'b1) $display("FAIL hold_release_ready: got %b want 1", obs_rdy_after); else passes++;
        nb = 2;
        fpos[0] = 22'h00000F; fneg[0] = 22'h000001;
        fpos[1] = 22'h000003; fneg[1] = 22'h000000;
        run_frame(0);
        checks++; if (obs_first_wait !== 0) $display("FAIL hold_next_accept: got wait %0d want 0", obs_first_wait); else passes++;
        checks++; if (obs_sum[0] !== 5) $display("FAIL hold_next_sum: got %0d want 5", obs_sum[0]); else passes++;
    endtask

    task automatic test_forced_end();
        nb = 16; use_last = 0; bubbles = 0; th_hi = 100; th_lo = -100;
        for (int b = 0; b < 16; b++) begin
            fpos[b] = '1;
            fneg[b] = '0;
        end
        run_frame(0);
        checks++; if (obs_sum[0] !== 352) $display("FAIL forced_sum: got %0d want 352", obs_sum[0]); else passes++;
        checks++; if (obs_ovf[0] !== 1'b1) $display("FAIL forced_ovf: got %b want 1", obs_ovf[0]); else passes++;
        checks++; if (obs_act[0] !== 2'b01) $display("FAIL forced_act: got %b want 01", obs_act[0]); else passes++;
        checks++; if (obs_sum[1] !== 127) $display("FAIL forced_sum_w8: got %0d want 127", obs_sum[1]); else passes++;
        checks++; if (obs_ovf[1] !== 1'b1) $display("FAIL forced_ovf_w8: got %b want 1", obs_ovf[1]); else passes++;
        use_last = 1;
        run_frame(0);
        checks++; if (obs_ovf[0] !== 1'b0) $display("FAIL last16_ovf: got %b want 0", obs_ovf[0]); else passes++;
        checks++; if (obs_sum[0] !== 352) $display("FAIL last16_sum: got %0d want 352", obs_sum[0]); else passes++;
        checks++; if (obs_ovf[1] !== 1'b1) $display("FAIL last16_sat_w8: got %b want 1", obs_ovf[1]); else passes++;
    endtask

    task automatic test_trunc();
        nb = 1; use_last = 1; bubbles = 0; th_hi = 4; th_lo = -4;
        fpos[0] = 22'h00007F;
        fneg[0] = 22'h300000;
        run_frame(0);
        checks++; if (obs_sum[2] !== 4) $display("FAIL trunc_sum: got %0d want 4", obs_sum[2]); else passes++;
        checks++; if (obs_act[2] !== 2'b00) $display("FAIL trunc_act_tie: got %b want 00", obs_act[2]); else passes++;
        checks++; if (obs_sum[0] !== 5) $display("FAIL exact_sum: got %0d want 5", obs_sum[0]); else passes++;
        checks++; if (obs_act[0] !== 2'b01) $display("FAIL exact_act: got %b want 01", obs_act[0]); else passes++;
    endtask

    task automatic test_random();
        int mode;
        for (int f = 0; f < 30; f++) begin
            nb       = int'($urandom_range(1, 16));
            use_last = (nb < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            bubbles  = 1;
            mode     = int'($urandom_range(0, 2));
            for (int b = 0; b < nb; b++) begin
                case (mode)
                    1:       begin fpos[b] = W'($urandom | $urandom); fneg[b] = W'($urandom & $urandom); end
                    2:       begin fpos[b] = W'($urandom & $urandom); fneg[b] = W'($urandom | $urandom); end
                    default: begin fpos[b] = W'($urandom);            fneg[b] = W'($urandom);            end
                endcase
            end
            th_lo = int'($urandom_range(0, 200)) - 100;
            th_hi = th_lo + int'($urandom_range(0, 100 - th_lo));
            compute_expected();
            if ($urandom_range(0, 3) == 0 && exp_sum[0] >= -100 && exp_sum[0] <= 100) begin
                th_hi = exp_sum[0];
                if (th_lo > th_hi) th_lo = th_hi;
                compute_expected();
            end
            run_frame(int'($urandom_range(0, 2)));
            checks++; if (obs_lat !== 2) $display("FAIL rand_latency f%0d: got %0d want 2", f, obs_lat); else passes++;
            checks++; if (obs_stall !== 1'b0) $display("FAIL rand_beat_stall f%0d: got %b want 0", f, obs_stall); else passes++;
            for (int v = 0; v < 3; v++) begin
                checks++;
                if (obs_sum[v] !== exp_sum[v])
                    $display("FAIL rand_sum f%0d cfg%0d: got %0d want %0d", f, v, obs_sum[v], exp_sum[v]);
                else passes++;
                checks++;
                if (obs_act[v] !== exp_act[v])
                    $display("FAIL rand_act f%0d cfg%0d: got %b want %b", f, v, obs_act[v], exp_act[v]);
                else passes++;
                checks++;
                if (obs_ovf[v] !== exp_ovf[v])
                    $display("FAIL rand_ovf f%0d cfg%0d: got %b want %b", f, v, obs_ovf[v], exp_ovf[v]);
                else passes++;
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_pos    = '0;
        bus.in_neg    = '0;
        bus.in_last   = 1'b0;
        bus.thr_hi    = '0;
        bus.thr_lo    = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_reset_mid_frame();
        test_single_beat();
        test_neg_frame();
        test_hold();
        test_forced_end();
        test_trunc();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
